// File: rtl/vdp_pkg.sv
// -----------------------------------------------------------------------------
// vdp_pkg
// Shared definitions for the vdp99 CPU-side interface blocks.
//   VRAM_AW        : VRAM address width
//   CMD_WRITE_BIT  : second mode-0 byte, 1 = address setup for write (no prefetch)
//   CMD_REG_BIT    : second mode-0 byte, 1 = config register write
//   vram_op_t      : one queued VRAM operation {we, addr, data}
// -----------------------------------------------------------------------------
package vdp_pkg;

   localparam int VRAM_AW       = 14;
   localparam int CMD_WRITE_BIT = 6;
   localparam int CMD_REG_BIT   = 7;

   typedef struct packed {
      logic               we;
      logic [VRAM_AW-1:0] addr;
      logic [7:0]         data;
   } vram_op_t;

endpackage

// File: rtl/vram_op_slot.sv
// -----------------------------------------------------------------------------
// vram_op_slot
// One-entry holding register for a VRAM operation.
//   clk      : system clock
//   reset_n  : synchronous active-low reset (clears op and valid)
//   load_i   : capture op_i and mark valid (wins over clear_i)
//   clear_i  : mark slot empty; the op contents are left as they were
//   op_i     : operation to capture
//   op_o     : held operation
//   valid_o  : slot holds an operation
// -----------------------------------------------------------------------------
module vram_op_slot
   import vdp_pkg::*;
(
   input  logic     clk,
   input  logic     reset_n,
   input  logic     load_i,
   input  logic     clear_i,
   input  vram_op_t op_i,
   output vram_op_t op_o,
   output logic     valid_o
);

   vram_op_t op_q;
   logic     valid_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         op_q    <= '0;
         valid_q <= 1'b0;
      end else if (load_i) begin
         op_q    <= op_i;
         valid_q <= 1'b1;
      end else if (clear_i) begin
         valid_q <= 1'b0;
      end
   end

   assign op_o    = op_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/vram_ifce.sv
// -----------------------------------------------------------------------------
// vram_ifce
// CPU-side VRAM port of the vdp99 VDP. Decodes the mode-0 address setup
// sequence, runs mode-1 data reads/writes through a read-ahead buffer with
// address auto-increment, and queues single-byte requests to the VRAM arbiter
// (one in-flight slot plus one pending slot).
//   clk, reset_n           : clock, synchronous active-low reset
//   wm0_tick / rm0_tick    : mode-0 write / status read strobes
//   wm1_tick / rm1_tick    : mode-1 VRAM data write / read strobes
//   din                    : CPU write data
//   dout                   : read-ahead buffer
//   vram_req/we/addr/wdata : request to arbiter, held until vram_ack
//   vram_ack / vram_rdata  : completion strobe and read data
//   busy                   : in-flight or pending slot occupied
//   ovf                    : sticky, an operation was dropped (queue full)
// AW must not exceed VRAM_AW (queued ops carry a VRAM_AW-bit address).
// -----------------------------------------------------------------------------
module vram_ifce
   import vdp_pkg::*;
#(
   parameter int AW = VRAM_AW
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          wm0_tick,
   input  logic          rm0_tick,
   input  logic          wm1_tick,
   input  logic          rm1_tick,
   input  logic [7:0]    din,
   output logic [7:0]    dout,
   output logic          vram_req,
   output logic          vram_we,
   output logic [AW-1:0] vram_addr,
   output logic [7:0]    vram_wdata,
   input  logic          vram_ack,
   input  logic [7:0]    vram_rdata,
   output logic          busy,
   output logic          ovf
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_REQ  = 1'b1;

   logic [0:0]    state_q, state_d;
   logic          phase_q, phase_d;
   logic [7:0]    lo_q, lo_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [7:0]    rbuf_q, rbuf_d;
   logic          ovf_q, ovf_d;
   logic          busy_q, busy_d;

   logic [AW-1:0] setup_addr;
   logic          ack;
   logic          enq;
   vram_op_t      new_op;

   logic          cur_load, cur_clear, cur_valid, cur_valid_d;
   logic          pend_load, pend_clear, pend_valid, pend_valid_d;
   logic          drop;
   vram_op_t      cur_in, cur_op, pend_op;

   // Address formed by the second mode-0 byte: {din[5:0], first byte}.
   assign setup_addr = AW'({din[5:0], lo_q});

   // An ack is only meaningful while a request is actually outstanding.
   assign ack = vram_ack && (state_q == ST_REQ);

   // -------------------------------------------------------------------------
   // CPU tick decode. Priority wm0 > rm0 > wm1 > rm1 if ticks collide.
   // -------------------------------------------------------------------------
   always_comb begin
      phase_d = phase_q;
      lo_d    = lo_q;
      addr_d  = addr_q;
      rbuf_d  = rbuf_q;
      enq     = 1'b0;
      new_op  = '0;

      // Read completion refills the read-ahead buffer; a same-cycle wm1
      // below overrides it since it is the newer CPU-visible event.
      if (ack && !cur_op.we) begin
         rbuf_d = vram_rdata;
      end

      if (wm0_tick) begin
         phase_d = ~phase_q;
         if (!phase_q) begin
            lo_d = din;
         end else if (!din[CMD_REG_BIT]) begin
            addr_d = setup_addr;
            if (!din[CMD_WRITE_BIT]) begin
               // Read setup: prefetch so the first rm1 finds data waiting.
               enq         = 1'b1;
               new_op.we   = 1'b0;
               new_op.addr = VRAM_AW'(setup_addr);
               addr_d      = setup_addr + AW'(1);
            end
         end
      end else if (rm0_tick) begin
         phase_d = 1'b0;
      end else if (wm1_tick) begin
         rbuf_d      = din;
         enq         = 1'b1;
         new_op.we   = 1'b1;
         new_op.addr = VRAM_AW'(addr_q);
         new_op.data = din;
         addr_d      = addr_q + AW'(1);
      end else if (rm1_tick) begin
         enq         = 1'b1;
         new_op.we   = 1'b0;
         new_op.addr = VRAM_AW'(addr_q);
         addr_d      = addr_q + AW'(1);
      end
   end

   // -------------------------------------------------------------------------
   // Two-entry queue control. The in-flight slot drives the request; the
   // pending slot moves up on ack. A new op always lands in whichever slot
   // is free after this edge, so an enqueue coinciding with ack never drops.
   // -------------------------------------------------------------------------
   always_comb begin
      cur_load   = 1'b0;
      cur_clear  = 1'b0;
      cur_in     = new_op;
      pend_load  = 1'b0;
      pend_clear = 1'b0;
      drop       = 1'b0;

      if (!cur_valid) begin
         cur_load = enq;
      end else if (ack) begin
         if (pend_valid) begin
            cur_load = 1'b1;
            cur_in   = pend_op;
            if (enq) begin
               pend_load = 1'b1;
            end else begin
               pend_clear = 1'b1;
            end
         end else if (enq) begin
            cur_load = 1'b1;
         end else begin
            cur_clear = 1'b1;
         end
      end else if (enq) begin
         if (!pend_valid) begin
            pend_load = 1'b1;
         end else begin
            drop = 1'b1;
         end
      end

      cur_valid_d  = cur_load  | (cur_valid  & ~cur_clear);
      pend_valid_d = pend_load | (pend_valid & ~pend_clear);
      busy_d       = cur_valid_d | pend_valid_d;
      ovf_d        = ovf_q | drop;
      state_d      = cur_valid_d ? ST_REQ : ST_IDLE;
   end

   vram_op_slot u_cur (
      .clk     (clk),
      .reset_n (reset_n),
      .load_i  (cur_load),
      .clear_i (cur_clear),
      .op_i    (cur_in),
      .op_o    (cur_op),
      .valid_o (cur_valid)
   );

   vram_op_slot u_pend (
      .clk     (clk),
      .reset_n (reset_n),
      .load_i  (pend_load),
      .clear_i (pend_clear),
      .op_i    (new_op),
      .op_o    (pend_op),
      .valid_o (pend_valid)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         phase_q <= 1'b0;
         lo_q    <= '0;
         addr_q  <= '0;
         rbuf_q  <= '0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         lo_q    <= lo_d;
         addr_q  <= addr_d;
         rbuf_q  <= rbuf_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
      end
   end

   assign vram_req   = (state_q == ST_REQ);
   assign vram_we    = cur_op.we;
   assign vram_addr  = AW'(cur_op.addr);
   assign vram_wdata = cur_op.data;
   assign dout       = rbuf_q;
   assign busy       = busy_q;
   assign ovf        = ovf_q;

endmodule

// File: tb/tb_vram_ifce.sv
// -----------------------------------------------------------------------------
// tb_vram_ifce
// Directed bench for vram_ifce. Inputs change on the falling edge, outputs
// are sampled on the falling edge. A tick task pulses one strobe for one
// rising edge; an ack task plays the arbiter.
// -----------------------------------------------------------------------------
module tb_vram_ifce;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        wm0_tick, rm0_tick, wm1_tick, rm1_tick;
   logic [7:0]  din;
   logic [7:0]  dout;
   logic        vram_req, vram_we;
   logic [13:0] vram_addr;
   logic [7:0]  vram_wdata;
   logic        vram_ack;
   logic [7:0]  vram_rdata;
   logic        busy, ovf;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   vram_ifce #(.AW(14)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .wm0_tick   (wm0_tick),
      .rm0_tick   (rm0_tick),
      .wm1_tick   (wm1_tick),
      .rm1_tick   (rm1_tick),
      .din        (din),
      .dout       (dout),
      .vram_req   (vram_req),
      .vram_we    (vram_we),
      .vram_addr  (vram_addr),
      .vram_wdata (vram_wdata),
      .vram_ack   (vram_ack),
      .vram_rdata (vram_rdata),
      .busy       (busy),
      .ovf        (ovf)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end else begin
         $display("[TB] ok   %s: 0x%0h", tag, obs);
      end
   endtask

   // Check the request currently presented to the arbiter.
   task automatic check_op(input string tag, input logic we, input logic [13:0] addr,
                           input logic [7:0] data);
      check({tag, ".req"},  32'(vram_req), 32'd1);
      check({tag, ".we"},   32'(vram_we),  32'(we));
      check({tag, ".addr"}, 32'(vram_addr), 32'(addr));
      if (we) check({tag, ".wdata"}, 32'(vram_wdata), 32'(data));
   endtask

   // 0=wm0, 1=rm0, 2=wm1, 3=rm1; active for exactly one rising edge.
   task automatic tick(input int kind, input logic [7:0] d);
      @(negedge clk);
      din = d;
      case (kind)
         0: wm0_tick = 1'b1;
         1: rm0_tick = 1'b1;
         2: wm1_tick = 1'b1;
         default: rm1_tick = 1'b1;
      endcase
      @(negedge clk);
      wm0_tick = 1'b0;
      rm0_tick = 1'b0;
      wm1_tick = 1'b0;
      rm1_tick = 1'b0;
   endtask

   // Arbiter: wait one cycle, then a single-cycle ack with read data.
   // Returns on the falling edge right after the ack edge.
   task automatic ack_op(input logic [7:0] rd);
      @(negedge clk);
      vram_ack   = 1'b1;
      vram_rdata = rd;
      @(negedge clk);
      vram_ack   = 1'b0;
      vram_rdata = 8'h00;
   endtask

   initial begin
      reset_n    = 1'b0;
      wm0_tick   = 1'b0;
      rm0_tick   = 1'b0;
      wm1_tick   = 1'b0;
      rm1_tick   = 1'b0;
      din        = 8'h00;
      vram_ack   = 1'b0;
      vram_rdata = 8'h00;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // Reset values
      check("rst.req",  32'(vram_req), 32'd0);
      check("rst.addr", 32'(vram_addr), 32'd0);
      check("rst.dout", 32'(dout), 32'd0);
      check("rst.busy", 32'(busy), 32'd0);
      check("rst.ovf",  32'(ovf), 32'd0);

      // Write setup 0x1234 (bit6 set, no prefetch) then three writes
      tick(0, 8'h34);
      tick(0, 8'h52);
      check("wsetup.noreq", 32'(vram_req), 32'd0);
      tick(2, 8'hAA);
      check_op("w0", 1'b1, 14'h1234, 8'hAA);
      check("w0.busy", 32'(busy), 32'd1);
      check("w0.dout", 32'(dout), 32'hAA);
      ack_op(8'h00);
      check("w0.done", 32'(vram_req), 32'd0);
      tick(2, 8'hBB);
      check_op("w1", 1'b1, 14'h1235, 8'hBB);
      ack_op(8'h00);
      tick(2, 8'hCC);
      check_op("w2", 1'b1, 14'h1236, 8'hCC);
      ack_op(8'h00);
      check("w2.done", 32'(vram_req), 32'd0);
      check("w2.dout", 32'(dout), 32'hCC);

      // Read setup 0x1000 with prefetch, then an rm1
      tick(0, 8'h00);
      tick(0, 8'h10);
      check_op("pf", 1'b0, 14'h1000, 8'h00);
      ack_op(8'h5A);
      check("pf.dout", 32'(dout), 32'h5A);
      check("pf.done", 32'(vram_req), 32'd0);
      tick(3, 8'h00);
      check("rm1.dout", 32'(dout), 32'h5A);
      check_op("rm1", 1'b0, 14'h1001, 8'h00);
      ack_op(8'h77);
      check("rm1.newdout", 32'(dout), 32'h77);

      // Address wrap at 0x3FFF
      tick(0, 8'hFF);
      tick(0, 8'h7F);
      tick(2, 8'h11);
      check_op("wrap0", 1'b1, 14'h3FFF, 8'h11);
      ack_op(8'h00);
      tick(2, 8'h22);
      check_op("wrap1", 1'b1, 14'h0000, 8'h22);
      ack_op(8'h00);

      // Overflow: three writes with no ack (address now 0x0001)
      tick(2, 8'hD1);
      tick(2, 8'hD2);
      tick(2, 8'hD3);
      check("ovf.flag", 32'(ovf), 32'd1);
      check("ovf.busy", 32'(busy), 32'd1);
      check_op("ovf.cur", 1'b1, 14'h0001, 8'hD1);
      ack_op(8'h00);
      check_op("ovf.pend", 1'b1, 14'h0002, 8'hD2);
      ack_op(8'h00);
      check("ovf.done", 32'(vram_req), 32'd0);
      check("ovf.idle", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      check("ovf.nothird", 32'(vram_req), 32'd0);
      check("ovf.sticky", 32'(ovf), 32'd1);
      tick(2, 8'hE0);
      check_op("ovf.incr", 1'b1, 14'h0004, 8'hE0);
      ack_op(8'h00);

      // Phase reset by rm0, register write does not touch VRAM
      tick(0, 8'h34);
      tick(1, 8'h00);
      tick(0, 8'h12);
      tick(0, 8'h40);
      check("ph.noreq", 32'(vram_req), 32'd0);
      tick(0, 8'h99);
      tick(0, 8'h81);
      check("reg.noreq", 32'(vram_req), 32'd0);
      tick(2, 8'h55);
      check_op("ph", 1'b1, 14'h0012, 8'h55);
      ack_op(8'h00);

      // Reset with a request in flight and one pending
      tick(2, 8'h61);
      tick(2, 8'h62);
      check_op("mid", 1'b1, 14'h0013, 8'h61);
      check("mid.busy", 32'(busy), 32'd1);
      reset_n = 1'b0;
      @(negedge clk);
      check("mrst.req",   32'(vram_req), 32'd0);
      check("mrst.we",    32'(vram_we), 32'd0);
      check("mrst.addr",  32'(vram_addr), 32'd0);
      check("mrst.wdata", 32'(vram_wdata), 32'd0);
      check("mrst.dout",  32'(dout), 32'd0);
      check("mrst.busy",  32'(busy), 32'd0);
      check("mrst.ovf",   32'(ovf), 32'd0);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);
      check("mrst.quiet", 32'(vram_req), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Hard stop in case something above stalls.
   initial begin
      #100000;
      $display("[TB] FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
